// File: rtl/lbp_pkg.sv
// Shared constants, FSM state type and pixel-geometry helper for the LBP image host.
package lbp_pkg;

  localparam int unsigned IMG_W = 128;
  localparam int unsigned IMG_H = 128;
  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 8;

  typedef enum logic [2:0] {
    StLoad,
    StClear,
    StReady,
    StRun,
    StDone
  } state_e;

  // True when the raster address lies on the outer one-pixel frame of the image.
  function automatic logic is_border(logic [AW-1:0] addr);
    int unsigned row;
    int unsigned col;
    row = 32'(addr) / IMG_W;
    col = 32'(addr) % IMG_W;
    return (row == 0) || (row == IMG_H - 1) || (col == 0) || (col == IMG_W - 1);
  endfunction

endpackage

// File: rtl/lbp_img_host_if.sv
// Loader, engine and readout signals of the LBP image host, with host (slave) and
// driver (master) views.
interface lbp_img_host_if;
  import lbp_pkg::*;

  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;
  logic          done;
  logic          restart;
  logic [AW-1:0] wr_count;
  logic          err_border;
  logic          err_early;

  modport slave (
    input  load_valid, load_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, res_addr, restart,
    output load_ready, gray_ready, gray_data, res_data, done, wr_count, err_border, err_early
  );

  modport master (
    output load_valid, load_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, res_addr, restart,
    input  load_ready, gray_ready, gray_data, res_data, done, wr_count, err_border, err_early
  );

endinterface

// File: rtl/lbp_img_ram.sv
// Single-write, single-read image RAM; the read register clocks on the falling edge
// when ReadNegEdge is set, otherwise on the rising edge.
module lbp_img_ram #(
  parameter int unsigned AW          = 14,
  parameter int unsigned DW          = 8,
  parameter bit          ReadNegEdge = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the read register is reset; array contents are left undefined.
  if (ReadNegEdge) begin : g_rd_neg
    always_ff @(negedge clk_i or posedge rst_i) begin
      if (rst_i)     rdata_o <= '0;
      else if (re_i) rdata_o <= mem_q[raddr_i];
    end
  end else begin : g_rd_pos
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     rdata_o <= '0;
      else if (re_i) rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/lbp_img_host.sv
// Image-side responder for the LBP engine: loads the gray image, zeroes the result image,
// serves engine reads and writes, then exposes the result image for readout.
module lbp_img_host
  import lbp_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  lbp_img_host_if.slave  bus
);

  localparam logic [AW-1:0] AddrMax = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] wr_count_q, wr_count_d;
  logic          err_border_q, err_border_d;
  logic          err_early_q, err_early_d;

  logic          gray_we;
  logic          res_we;
  logic [AW-1:0] res_waddr;
  logic [DW-1:0] res_wdata;
  logic [DW-1:0] res_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StLoad;
      ptr_q        <= '0;
      wr_count_q   <= '0;
      err_border_q <= 1'b0;
      err_early_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wr_count_q   <= wr_count_d;
      err_border_q <= err_border_d;
      err_early_q  <= err_early_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    wr_count_d   = wr_count_q;
    err_border_d = err_border_q;
    err_early_d  = err_early_q;
    gray_we      = 1'b0;
    res_we       = 1'b0;
    res_waddr    = ptr_q;
    res_wdata    = '0;

    if (bus.gray_req && (state_q == StLoad || state_q == StClear)) err_early_d = 1'b1;

    unique case (state_q)
      StLoad: begin
        if (bus.load_valid) begin
          gray_we = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          if (ptr_q == AddrMax) state_d = StClear;
        end
      end
      // ptr_q wraps to zero at the end of LOAD, so it doubles as the clear pointer.
      StClear: begin
        res_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == AddrMax) state_d = StReady;
      end
      StReady: begin
        if (bus.gray_req) state_d = StRun;
      end
      StRun: begin
        if (bus.lbp_valid) begin
          res_we    = 1'b1;
          res_waddr = bus.lbp_addr;
          res_wdata = bus.lbp_data;
          if (wr_count_q != AddrMax) wr_count_d = wr_count_q + 1'b1;
          if (is_border(bus.lbp_addr)) err_border_d = 1'b1;
        end
        if (bus.finish) state_d = StDone;
      end
      StDone: begin
        if (bus.restart) begin
          state_d      = StLoad;
          ptr_d        = '0;
          wr_count_d   = '0;
          err_border_d = 1'b0;
          err_early_d  = 1'b0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  lbp_img_ram #(
    .AW          (AW),
    .DW          (DW),
    .ReadNegEdge (1'b1)
  ) u_gray_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (gray_we),
    .waddr_i (ptr_q),
    .wdata_i (bus.load_data),
    .re_i    (bus.gray_req),
    .raddr_i (bus.gray_addr),
    .rdata_o (bus.gray_data)
  );

  lbp_img_ram #(
    .AW          (AW),
    .DW          (DW),
    .ReadNegEdge (1'b0)
  ) u_res_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (res_we),
    .waddr_i (res_waddr),
    .wdata_i (res_wdata),
    .re_i    (1'b1),
    .raddr_i (bus.res_addr),
    .rdata_o (res_rdata)
  );

  assign bus.load_ready = (state_q == StLoad);
  assign bus.gray_ready = (state_q == StReady) || (state_q == StRun);
  assign bus.done       = (state_q == StDone);
  assign bus.res_data   = (state_q == StDone) ? res_rdata : '0;
  assign bus.wr_count   = wr_count_q;
  assign bus.err_border = err_border_q;
  assign bus.err_early  = err_early_q;

endmodule

// File: tb/tb_lbp_img_host.sv
// Self-checking bench for lbp_img_host: array-based image model, write vector table and
// randomized reads, writes and readouts.
module tb_lbp_img_host;
  import lbp_pkg::*;

  localparam int NPix = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lbp_img_host_if bus ();

  lbp_img_host dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] m_gray [NPix];
  logic [DW-1:0] m_res  [NPix];
  int            m_wc;
  bit            m_border;
  int            n_pass  = 0;
  int            n_total = 0;
  int            last_rd;

  typedef struct {
    int addr;
    int data;
    int exp_wc;
    int exp_border;
  } wr_vec_t;

  wr_vec_t wr_tab [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic bit border_px(input int a);
    int row;
    int col;
    row = a / IMG_W;
    col = a % IMG_W;
    return row == 0 || row == IMG_H - 1 || col == 0 || col == IMG_W - 1;
  endfunction

  task automatic idle_inputs();
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.gray_req   = 1'b0;
    bus.gray_addr  = '0;
    bus.lbp_valid  = 1'b0;
    bus.lbp_addr   = '0;
    bus.lbp_data   = '0;
    bus.finish     = 1'b0;
    bus.res_addr   = '0;
    bus.restart    = 1'b0;
  endtask

  task automatic reset_outs(input string p);
    check({p, "_load_ready"}, 32'(bus.load_ready), 1);
    check({p, "_gray_ready"}, 32'(bus.gray_ready), 0);
    check({p, "_gray_data"},  32'(bus.gray_data),  0);
    check({p, "_res_data"},   32'(bus.res_data),   0);
    check({p, "_done"},       32'(bus.done),       0);
    check({p, "_wr_count"},   32'(bus.wr_count),   0);
    check({p, "_err_border"}, 32'(bus.err_border), 0);
    check({p, "_err_early"},  32'(bus.err_early),  0);
  endtask

  task automatic load_image(input bit rnd);
    for (int i = 0; i < NPix; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = rnd ? DW'($urandom) : i[7:0];
      m_gray[i]      = bus.load_data;
      if (i == NPix - 1) check("load_ready_last", 32'(bus.load_ready), 1);
      tick();
    end
    bus.load_valid = 1'b0;
    check("load_ready_drop", 32'(bus.load_ready), 0);
  endtask

  // Optionally pokes an early gray_req and stray load strobes while the result RAM clears.
  task automatic wait_ready(input bit poke);
    int n;
    n = 0;
    while (bus.gray_ready !== 1'b1 && n < 20000) begin
      if (poke) begin
        bus.gray_req   = (n == 100);
        bus.gray_addr  = AW'(n);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
      end
      tick();
      n++;
    end
    bus.gray_req   = 1'b0;
    bus.load_valid = 1'b0;
    check("clear_len", 32'(n), 32'(NPix));
    for (int i = 0; i < NPix; i++) m_res[i] = '0;
  endtask

  task automatic rd_check(input int a, input string name);
    bus.gray_req  = 1'b1;
    bus.gray_addr = AW'(a);
    @(negedge clk);
    #1;
    check(name, 32'(bus.gray_data), 32'(m_gray[a]));
    last_rd = a;
    tick();
  endtask

  task automatic wr(input int a, input int d, input bit fin);
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = AW'(a);
    bus.lbp_data  = DW'(d);
    bus.finish    = fin;
    tick();
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b0;
    m_res[a] = DW'(d);
    if (m_wc < NPix - 1) m_wc++;
    if (border_px(a)) m_border = 1'b1;
  endtask

  task automatic res_check(input int a);
    bus.res_addr = AW'(a);
    tick();
    check("readout", 32'(bus.res_data), 32'(m_res[a]));
  endtask

  initial begin
    wr_tab[0] = '{addr: 130,   data: 'h5A, exp_wc: 1, exp_border: 0};
    wr_tab[1] = '{addr: 258,   data: 'h44, exp_wc: 2, exp_border: 0};
    wr_tab[2] = '{addr: 0,     data: 'h11, exp_wc: 3, exp_border: 1};
    wr_tab[3] = '{addr: 16383, data: 'h22, exp_wc: 4, exp_border: 1};

    idle_inputs();
    reset = 1'b1;
    #12;
    reset_outs("por");
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Run 1: random image, enter RUN, write once, then reset mid-run.
    m_wc = 0;
    m_border = 1'b0;
    load_image(1'b1);
    wait_ready(1'b0);
    check("run1_gray_ready", 32'(bus.gray_ready), 1);
    for (int i = 0; i < 20; i++) rd_check(int'($urandom_range(0, NPix - 1)), "run1_rd");
    check("run1_in_run_ready", 32'(bus.gray_ready), 1);
    bus.gray_req = 1'b0;
    wr(777, 'h99, 1'b0);
    check("run1_wc", 32'(bus.wr_count), 1);
    reset = 1'b1;
    #2;
    reset_outs("midrun");
    tick();
    reset = 1'b0;
    tick();

    // Run 2: ramp image, early request during CLEAR, full RUN and readout.
    m_wc = 0;
    m_border = 1'b0;
    load_image(1'b0);
    wait_ready(1'b1);
    check("early_flag", 32'(bus.err_early), 1);
    check("ready_done", 32'(bus.done), 0);
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = AW'(300);
    bus.lbp_data  = 8'h77;
    tick();
    bus.lbp_valid = 1'b0;
    check("ready_wr_ignored", 32'(bus.wr_count), 0);
    rd_check(129, "rd_129");
    check("rd_129_const", 32'(bus.gray_data), 'h81);
    bus.gray_req  = 1'b0;
    bus.gray_addr = AW'(5);
    @(negedge clk);
    #1;
    check("rd_hold", 32'(bus.gray_data), 32'(m_gray[last_rd]));
    tick();
    for (int i = 0; i < 30; i++) rd_check(int'($urandom_range(0, NPix - 1)), "run2_rd");
    bus.gray_req = 1'b0;

    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    check("restart_ignored_done", 32'(bus.done), 0);
    check("restart_ignored_ready", 32'(bus.gray_ready), 1);

    foreach (wr_tab[i]) begin
      wr(wr_tab[i].addr, wr_tab[i].data, 1'b0);
      check("tab_wr_count", 32'(bus.wr_count), 32'(wr_tab[i].exp_wc));
      check("tab_err_border", 32'(bus.err_border), 32'(wr_tab[i].exp_border));
    end
    for (int i = 0; i < 20; i++) begin
      wr(int'($urandom_range(0, NPix - 1)), int'($urandom_range(0, 255)), 1'b0);
      check("rnd_wr_count", 32'(bus.wr_count), 32'(m_wc));
    end
    wr(5000, 'hC3, 1'b1);
    check("fin_done", 32'(bus.done), 1);
    check("fin_gray_ready", 32'(bus.gray_ready), 0);
    check("fin_wr_count", 32'(bus.wr_count), 32'(m_wc));
    check("fin_err_border", 32'(bus.err_border), 32'(m_border));
    check("fin_err_early", 32'(bus.err_early), 1);

    res_check(130);
    res_check(258);
    res_check(0);
    res_check(16383);
    res_check(5000);
    res_check(300);
    res_check(777);
    for (int i = 0; i < 20; i++) res_check(int'($urandom_range(0, NPix - 1)));

    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    check("reload_load_ready", 32'(bus.load_ready), 1);
    check("reload_done", 32'(bus.done), 0);
    check("reload_wr_count", 32'(bus.wr_count), 0);
    check("reload_err_border", 32'(bus.err_border), 0);
    check("reload_err_early", 32'(bus.err_early), 0);
    check("reload_res_data", 32'(bus.res_data), 0);
    check("reload_gray_ready", 32'(bus.gray_ready), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
